// File: rtl/beta_cycle_sequencer.sv
// Multi-cycle sequencer for a Beta-style RISC datapath.
// It steps each instruction through FETCH, EXEC, an optional MEM access and commit.
// It gates the decoder's write strobes.
// It inserts one-cycle trap slots for illegal opcodes, bus timeouts and interrupts.
module beta_cycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [5:0]       OPCODE,
  input  logic             IMEM_ACK,
  input  logic             DMEM_ACK,
  input  logic             IRQ,
  input  logic             SUPERVISOR,
  output logic             IMEM_REQ,
  output logic             IR_LE,
  output logic             DMEM_REQ,
  output logic             DMEM_WE,
  output logic             WERF_EN,
  output logic             PC_LE,
  output logic             PCSEL_OVR_EN,
  output logic [2:0]       PCSEL_OVR,
  output logic             WASEL_OVR,
  output logic [1:0]       TRAP_CAUSE,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] INSTRET
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_TRAP  = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_ILLOP  = 2'd1;
  localparam logic [1:0] CAUSE_IRQ    = 2'd2;
  localparam logic [1:0] CAUSE_BUSERR = 2'd3;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_LDR = 6'h1F;

  // The timeout counter only has to reach MEM_TIMEOUT-1, so it is sized for that value.
  localparam int TW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LAST_I);

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              st_q, st_d;
  logic              commit;

  function automatic logic is_illegal(input logic [5:0] op);
    return (op <= 6'h17) ||
           (op inside {6'h1A, 6'h1C, 6'h27, 6'h2B, 6'h2F, 6'h37, 6'h3B, 6'h3F});
  endfunction

  // State and bookkeeping registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      cause_q   <= 2'd0;
      instret_q <= '0;
      tmo_q     <= '0;
      st_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
      tmo_q     <= tmo_d;
      st_q      <= st_d;
    end
  end

  // Next-state and output decode from the registered state and the current inputs.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    cause_d      = cause_q;
    instret_d    = instret_q;
    tmo_d        = tmo_q;
    st_d         = st_q;
    commit       = 1'b0;
    IMEM_REQ     = 1'b0;
    IR_LE        = 1'b0;
    DMEM_REQ     = 1'b0;
    DMEM_WE      = 1'b0;
    WERF_EN      = 1'b0;
    PC_LE        = 1'b0;
    PCSEL_OVR_EN = 1'b0;
    PCSEL_OVR    = 3'd0;
    WASEL_OVR    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_ACK) begin
          IR_LE   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_illegal(OPCODE)) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLOP;
        end else if (OPCODE == OP_LD || OPCODE == OP_ST || OPCODE == OP_LDR) begin
          state_d = S_MEM;
          tmo_d   = '0;
          st_d    = (OPCODE == OP_ST);
        end else begin
          commit  = 1'b1;
          WERF_EN = 1'b1;
          PC_LE   = 1'b1;
        end
      end
      S_MEM: begin
        DMEM_REQ = 1'b1;
        DMEM_WE  = st_q;
        if (DMEM_ACK) begin
          commit  = 1'b1;
          PC_LE   = 1'b1;
          WERF_EN = !st_q;
        end else if (MEM_TIMEOUT > 0 && tmo_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUSERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_TRAP: begin
        PCSEL_OVR_EN = 1'b1;
        WASEL_OVR    = 1'b1;
        WERF_EN      = 1'b1;
        PC_LE        = 1'b1;
        PCSEL_OVR    = (cause_q == CAUSE_IRQ) ? 3'd4 : 3'd3;
        state_d      = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // An instruction boundary is where a pending, unmasked interrupt is taken.
    if (commit) begin
      instret_d = instret_q + CNT_W'(1);
      if (pend_q && !SUPERVISOR) begin
        state_d = S_TRAP;
        cause_d = CAUSE_IRQ;
        pend_d  = 1'b0;
      end else begin
        state_d = S_FETCH;
      end
    end

    // A new request wins over the clear, so an edge arriving during entry is not lost.
    if (IRQ && state_q != S_IDLE) pend_d = 1'b1;
  end

  assign STATE      = state_q;
  assign TRAP_CAUSE = cause_q;
  assign INSTRET    = instret_q;

endmodule

// File: doc/beta_cycle_sequencer.md
Name: beta_cycle_sequencer

Overview:
Multi-cycle sequencer for the Beta-style RISC datapath. It steps each instruction through fetch, execute, optional data-memory access and commit, and gates the control-logic write strobes. It also inserts trap cycles for illegal opcodes, bus timeouts and interrupts by overriding PCSEL and forcing a write to XP. It sits between the instruction/data memory handshakes and the opcode-ROM control decoder.

Parameters:
MEM_TIMEOUT, 16, maximum wait in MEM for DMEM_ACK, in cycles; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
CLK  input  1  system clock, rising edge.
RESET_N  input  1  reset; asynchronous assert, active-low.
OPCODE  input  6  IR[31:26]; valid from the cycle after IR_LE.
IMEM_ACK  input  1  instruction word valid this cycle.
DMEM_ACK  input  1  data access complete this cycle.
IRQ  input  1  external interrupt request, level or pulse.
SUPERVISOR  input  1  PC[31]; interrupts are blocked while it is 1.
IMEM_REQ  output  1  instruction fetch request.
IR_LE  output  1  IR load enable.
DMEM_REQ  output  1  data memory request.
DMEM_WE  output  1  data memory write (ST).
WERF_EN  output  1  register-file write enable, ANDed with the decoder's WERF.
PC_LE  output  1  PC update enable.
PCSEL_OVR_EN  output  1  selects PCSEL_OVR in place of the decoder's PCSEL.
PCSEL_OVR  output  3  3 = ILLOP vector, 4 = XADR (interrupt) vector.
WASEL_OVR  output  1  forces the write address to XP (R30).
TRAP_CAUSE  output  2  0 = none, 1 = ILLOP, 2 = IRQ, 3 = BUSERR; held until the next trap.
STATE  output  3  current state, for debug.
INSTRET  output  CNT_W  retired-instruction count.

Behaviour:
- State encoding: IDLE = 0, FETCH = 1, EXEC = 2, MEM = 3, TRAP = 4. All state is registered.
- Outputs are decoded combinationally from the registered state and inputs.
- Async reset (RESET_N = 0):
  - state goes to IDLE; all outputs, the IRQ pending latch, TRAP_CAUSE, INSTRET and the timeout counter go to 0.
  - Requests drop in the same cycle, including mid-fetch or mid-MEM.
- IDLE: after RESET_N rises, wait one clock, then go to FETCH.
- FETCH: IMEM_REQ = 1 every cycle.
  - On the cycle IMEM_ACK = 1: IR_LE = 1 for one cycle, then go to EXEC.
  - There is no limit on the fetch wait.
- EXEC: classify OPCODE.
  - Illegal opcodes are 0x00–0x17, 0x1A, 0x1C, 0x27, 0x2B, 0x2F, 0x37, 0x3B and 0x3F. They go to TRAP with cause ILLOP. No WERF_EN, no PC_LE.
  - LD (0x18), ST (0x19) and LDR (0x1F) go to MEM. The timeout counter clears on entry.
  - All other opcodes (ALU, ALU-constant, JMP, BEQ, BNE) commit in this cycle: WERF_EN = 1, PC_LE = 1, INSTRET += 1.
- MEM: DMEM_REQ = 1; DMEM_WE = 1 only for ST.
  - On the cycle DMEM_ACK = 1, commit: PC_LE = 1, INSTRET += 1, and WERF_EN = 1 only for LD/LDR.
  - If MEM_TIMEOUT > 0 and the counter reaches MEM_TIMEOUT - 1 without an ack, go to TRAP with cause BUSERR. No commit. Requests drop on entry to TRAP.
- After a commit the next state is TRAP with cause IRQ if the pending latch is 1 and SUPERVISOR = 0; otherwise FETCH.
- IRQ pending latch:
  - Set by any cycle with IRQ = 1 outside IDLE.
  - Cleared only when the IRQ trap is entered. IRQ and clear in the same cycle leaves it set.
  - While SUPERVISOR = 1 the interrupt is deferred, never dropped.
- TRAP: lasts exactly one cycle, then FETCH.
  - Asserts PCSEL_OVR_EN = 1, WASEL_OVR = 1, WERF_EN = 1 and PC_LE = 1, so XP receives PC+4 of the faulting or next instruction.
  - PCSEL_OVR = 4 for IRQ, 3 otherwise. INSTRET does not increment.
- Trap priority: a BUSERR or ILLOP trap wins over an IRQ; the pending latch stays set and is taken at the next boundary.
- TRAP_CAUSE updates on TRAP entry.
- INSTRET wraps modulo 2^CNT_W.
- WERF_EN, PC_LE, IR_LE and DMEM_WE are 0 in every state or cycle not listed above.

Test Plan:
- Reset release, OPCODE = 0x20 (ADD), IMEM_ACK 2 cycles after FETCH entry:
  - IMEM_REQ high 3 cycles, IR_LE pulses once, next cycle WERF_EN = PC_LE = 1, INSTRET = 1.
  - STATE sequence 0,1,1,1,2,1.
- OPCODE = 0x18 (LD), DMEM_ACK on the 3rd MEM cycle: DMEM_REQ high 3 cycles, DMEM_WE = 0, WERF_EN and PC_LE pulse with the ack, then FETCH.
- OPCODE = 0x19 (ST), immediate ack: DMEM_WE = 1 with DMEM_REQ, WERF_EN stays 0, PC_LE = 1, INSTRET increments.
- OPCODE = 0x00:
  - EXEC gives no commit; TRAP cycle shows PCSEL_OVR_EN = 1, PCSEL_OVR = 3, WASEL_OVR = 1, TRAP_CAUSE = 1.
  - INSTRET unchanged.
- One-cycle IRQ pulse during an LD MEM wait:
  - SUPERVISOR = 0: after commit, TRAP with PCSEL_OVR = 4, TRAP_CAUSE = 2.
  - SUPERVISOR = 1: instruction commits, no trap; trap taken at the first boundary after SUPERVISOR drops.
- MEM_TIMEOUT = 8, no DMEM_ACK: TRAP entered after the 8th MEM cycle with TRAP_CAUSE = 3.
- Repeat with RESET_N low in MEM cycle 4: all outputs 0 immediately, STATE = 0.
